// File: rtl/ir2_stage.sv
// Decode-stage instruction register (IR2) with an 8-bit-per-cycle multiplier operand sequencer.
// Optional: define IR2_MUL_EARLY_TERM_EN to end the multiply once the remaining operand bits are zero.
module ir2_stage #(
    parameter int unsigned MUL_STEPS = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            IR1_IN,
    input  logic                   IR1_VALID,
    output logic                   IR1_READY,
    input  logic                   STALL,
    input  logic                   FLUSH,
    input  logic                   MUL_START,
    input  logic [8*MUL_STEPS-1:0] RS_VAL,
    output logic [31:0]            IR2,
    output logic                   IR2_VALID,
    output logic [11:0]            IR2110,
    output logic [7:0]             IR270,
    output logic [23:0]            IR2230,
    output logic [7:0]             IR2_MUL70,
    output logic                   MUL_BUSY,
    output logic                   MUL_LAST
);

    localparam int unsigned RsW   = 8 * MUL_STEPS;
    localparam int unsigned StepW = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [StepW-1:0] LastStep = StepW'(MUL_STEPS - 1);

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e           state_q;
    logic [31:0]      ir2_q;
    logic             ir2_valid_q;
    logic [RsW-1:0]   shreg_q;
    logic [StepW-1:0] step_q;
    logic             mul_busy;
    logic             last_cond;

    assign mul_busy = (state_q == StMul);

`ifdef IR2_MUL_EARLY_TERM_EN
    // Nothing left above the current chunk: this chunk is the final one.
    assign last_cond = (step_q == LastStep) || ((shreg_q >> 8) == '0);
`else
    assign last_cond = (step_q == LastStep);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            ir2_q       <= '0;
            ir2_valid_q <= 1'b0;
            shreg_q     <= '0;
            step_q      <= '0;
        end else begin
            if (FLUSH) begin
                ir2_q       <= '0;
                ir2_valid_q <= 1'b0;
            end else if (!(STALL || mul_busy)) begin
                if (IR1_VALID) begin
                    ir2_q       <= IR1_IN;
                    ir2_valid_q <= 1'b1;
                end else begin
                    ir2_valid_q <= 1'b0;
                end
            end

            case (state_q)
                StIdle: begin
                    if (MUL_START && ir2_valid_q && !FLUSH) begin
                        state_q <= StMul;
                        shreg_q <= RS_VAL;
                        step_q  <= '0;
                    end
                end
                StMul: begin
                    if (FLUSH || last_cond) begin
                        state_q <= StIdle;
                        shreg_q <= '0;
                        step_q  <= '0;
                    end else begin
                        shreg_q <= shreg_q >> 8;
                        step_q  <= step_q + StepW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign IR1_READY = !STALL && !mul_busy;
    assign IR2       = ir2_q;
    assign IR2_VALID = ir2_valid_q;
    assign IR2110    = ir2_q[11:0];
    assign IR270     = ir2_q[7:0];
    assign IR2230    = ir2_q[23:0];
    assign MUL_BUSY  = mul_busy;
    assign MUL_LAST  = mul_busy && last_cond;
    assign IR2_MUL70 = mul_busy ? shreg_q[7:0] : 8'h00;

endmodule

// File: tb/tb_ir2_stage.sv
// Directed self-checking bench for ir2_stage: load, stall/flush, multiply slicing, async reset.
module tb_ir2_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IR1_IN;
    logic        IR1_VALID;
    logic        IR1_READY;
    logic        STALL;
    logic        FLUSH;
    logic        MUL_START;
    logic [31:0] RS_VAL;
    logic [31:0] IR2;
    logic        IR2_VALID;
    logic [11:0] IR2110;
    logic [7:0]  IR270;
    logic [23:0] IR2230;
    logic [7:0]  IR2_MUL70;
    logic        MUL_BUSY;
    logic        MUL_LAST;

    int checks   = 0;
    int failures = 0;

    ir2_stage #(.MUL_STEPS(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IR1_IN    (IR1_IN),
        .IR1_VALID (IR1_VALID),
        .IR1_READY (IR1_READY),
        .STALL     (STALL),
        .FLUSH     (FLUSH),
        .MUL_START (MUL_START),
        .RS_VAL    (RS_VAL),
        .IR2       (IR2),
        .IR2_VALID (IR2_VALID),
        .IR2110    (IR2110),
        .IR270     (IR270),
        .IR2230    (IR2230),
        .IR2_MUL70 (IR2_MUL70),
        .MUL_BUSY  (MUL_BUSY),
        .MUL_LAST  (MUL_LAST)
    );

    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1; IR1_IN = '0; IR1_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        MUL_START = 1'b0; RS_VAL = '0;
        #12;
        checks++;
        if (IR2 !== 32'h0 || IR2_VALID !== 1'b0 || MUL_BUSY !== 1'b0 || MUL_LAST !== 1'b0
            || IR2_MUL70 !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got ir2=%h v=%b busy=%b last=%b mul=%h exp all zero",
                     IR2, IR2_VALID, MUL_BUSY, MUL_LAST, IR2_MUL70);
        end
        checks++;
        if (IR1_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=1", IR1_READY);
        end
        RST = 1'b0;
    endtask

    task automatic test_load();
        IR1_IN = 32'hE3A0_1234; IR1_VALID = 1'b1;
        tick();
        checks++;
        if (IR2 !== 32'hE3A01234 || IR2_VALID !== 1'b1) begin
            failures++;
            $display("FAIL load_ir2 got=%h v=%b exp=e3a01234 v=1", IR2, IR2_VALID);
        end
        checks++;
        if (IR2110 !== 12'h234 || IR270 !== 8'h34 || IR2230 !== 24'hA01234) begin
            failures++;
            $display("FAIL load_fields got=%h/%h/%h exp=234/34/a01234", IR2110, IR270, IR2230);
        end
    endtask

    task automatic test_stall();
        STALL = 1'b1;
        #1;
        checks++;
        if (IR1_READY !== 1'b0) begin
            failures++;
            $display("FAIL stall_ready got=%b exp=0", IR1_READY);
        end
        for (int i = 0; i < 3; i++) begin
            IR1_IN = 32'h1111_0000 + i;
            tick();
            checks++;
            if (IR2 !== 32'hE3A01234 || IR2_VALID !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h v=%b exp=e3a01234 v=1", i, IR2, IR2_VALID);
            end
        end
        FLUSH = 1'b1;
        tick();
        checks++;
        if (IR2_VALID !== 1'b0 || IR2 !== 32'h0) begin
            failures++;
            $display("FAIL flush_stall got=%h v=%b exp=0 v=0", IR2, IR2_VALID);
        end
        FLUSH = 1'b0; STALL = 1'b0;
    endtask

    task automatic test_bubble();
        IR1_IN = 32'hCAFE_0001; IR1_VALID = 1'b1;
        tick();
        IR1_VALID = 1'b0;
        tick();
        checks++;
        if (IR2_VALID !== 1'b0 || IR2 !== 32'hCAFE0001) begin
            failures++;
            $display("FAIL bubble got=%h v=%b exp=cafe0001 v=0", IR2, IR2_VALID);
        end
    endtask

    task automatic test_mul();
        logic [7:0] seq [4];
        seq = '{8'h11, 8'h22, 8'h44, 8'h88};
        IR1_IN = 32'hE000_0091; IR1_VALID = 1'b1;
        tick();
        STALL = 1'b1; MUL_START = 1'b1; RS_VAL = 32'h8844_2211; IR1_IN = 32'hDEAD_BEEF;
        tick();
        MUL_START = 1'b0; STALL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            checks++;
            if (IR2_MUL70 !== seq[i] || MUL_BUSY !== 1'b1 || MUL_LAST !== (i == 3)) begin
                failures++;
                $display("FAIL mul_step%0d got mul=%h busy=%b last=%b exp mul=%h busy=1 last=%b",
                         i, IR2_MUL70, MUL_BUSY, MUL_LAST, seq[i], (i == 3));
            end
            checks++;
            if (IR2 !== 32'hE0000091 || IR2_VALID !== 1'b1 || IR1_READY !== 1'b0) begin
                failures++;
                $display("FAIL mul_frozen%0d got ir2=%h v=%b rdy=%b exp e0000091 v=1 rdy=0",
                         i, IR2, IR2_VALID, IR1_READY);
            end
        end
        MUL_START = 1'b1;  // arrives while MUL_LAST is high: must be ignored
        tick();
        checks++;
        if (MUL_BUSY !== 1'b0 || IR2_MUL70 !== 8'h00 || MUL_LAST !== 1'b0) begin
            failures++;
            $display("FAIL mul_b2b got busy=%b mul=%h last=%b exp 0/00/0",
                     MUL_BUSY, IR2_MUL70, MUL_LAST);
        end
        checks++;
        if (IR2 !== 32'hE0000091 || IR1_READY !== 1'b1) begin
            failures++;
            $display("FAIL mul_exit got ir2=%h rdy=%b exp e0000091 rdy=1", IR2, IR1_READY);
        end
        MUL_START = 1'b0;
        tick();
        checks++;
        if (IR2 !== 32'hDEADBEEF || IR2_VALID !== 1'b1 || MUL_BUSY !== 1'b0) begin
            failures++;
            $display("FAIL mul_reload got ir2=%h v=%b busy=%b exp deadbeef v=1 busy=0",
                     IR2, IR2_VALID, MUL_BUSY);
        end
    endtask

    task automatic test_flush_mul();
        STALL = 1'b1; MUL_START = 1'b1; RS_VAL = 32'h8844_2211;
        tick();
        MUL_START = 1'b0; STALL = 1'b0;
        tick();
        checks++;
        if (IR2_MUL70 !== 8'h22 || MUL_BUSY !== 1'b1) begin
            failures++;
            $display("FAIL flush_mul_pre got mul=%h busy=%b exp 22/1", IR2_MUL70, MUL_BUSY);
        end
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        checks++;
        if (MUL_BUSY !== 1'b0 || IR2_MUL70 !== 8'h00 || IR2_VALID !== 1'b0 || MUL_LAST !== 1'b0)
        begin
            failures++;
            $display("FAIL flush_mul got busy=%b mul=%h v=%b last=%b exp all 0",
                     MUL_BUSY, IR2_MUL70, IR2_VALID, MUL_LAST);
        end
        IR1_IN = 32'h0000_5A5A; IR1_VALID = 1'b1;
        tick();
        FLUSH = 1'b1; MUL_START = 1'b1;
        tick();
        FLUSH = 1'b0; MUL_START = 1'b0;
        checks++;
        if (MUL_BUSY !== 1'b0 || IR2_VALID !== 1'b0) begin
            failures++;
            $display("FAIL flush_start got busy=%b v=%b exp 0/0", MUL_BUSY, IR2_VALID);
        end
    endtask

    task automatic test_async_reset();
        IR1_IN = 32'h0F0F_0F0F; IR1_VALID = 1'b1;
        tick();
        STALL = 1'b1; MUL_START = 1'b1; RS_VAL = 32'h8844_2211;
        tick();
        MUL_START = 1'b0; STALL = 1'b0; IR1_VALID = 1'b0;
        checks++;
        if (MUL_BUSY !== 1'b1 || IR2 !== 32'h0F0F0F0F) begin
            failures++;
            $display("FAIL areset_pre got busy=%b ir2=%h exp 1/0f0f0f0f", MUL_BUSY, IR2);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (IR2 !== 32'h0 || IR2_VALID !== 1'b0 || MUL_BUSY !== 1'b0 || MUL_LAST !== 1'b0
            || IR2_MUL70 !== 8'h00) begin
            failures++;
            $display("FAIL areset got ir2=%h v=%b busy=%b last=%b mul=%h exp all zero",
                     IR2, IR2_VALID, MUL_BUSY, MUL_LAST, IR2_MUL70);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (MUL_BUSY !== 1'b0 || IR2_VALID !== 1'b0) begin
            failures++;
            $display("FAIL areset_post got busy=%b v=%b exp 0/0", MUL_BUSY, IR2_VALID);
        end
    endtask

    task automatic test_early_term();
        IR1_IN = 32'h1234_0000; IR1_VALID = 1'b1;
        tick();
        STALL = 1'b1; MUL_START = 1'b1; RS_VAL = 32'h0000_00FF;
        tick();
        MUL_START = 1'b0; STALL = 1'b0; IR1_VALID = 1'b0;
        checks++;
`ifdef IR2_MUL_EARLY_TERM_EN
        if (IR2_MUL70 !== 8'hFF || MUL_BUSY !== 1'b1 || MUL_LAST !== 1'b1) begin
            failures++;
            $display("FAIL early_first got mul=%h busy=%b last=%b exp ff/1/1",
                     IR2_MUL70, MUL_BUSY, MUL_LAST);
        end
`else
        if (IR2_MUL70 !== 8'hFF || MUL_BUSY !== 1'b1 || MUL_LAST !== 1'b0) begin
            failures++;
            $display("FAIL early_first got mul=%h busy=%b last=%b exp ff/1/0",
                     IR2_MUL70, MUL_BUSY, MUL_LAST);
        end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (IR2_MUL70 !== 8'h00 || MUL_BUSY !== 1'b1 || MUL_LAST !== (i == 3)) begin
                failures++;
                $display("FAIL early_step%0d got mul=%h busy=%b last=%b exp 00/1/%b",
                         i, IR2_MUL70, MUL_BUSY, MUL_LAST, (i == 3));
            end
        end
`endif
        tick();
        checks++;
        if (MUL_BUSY !== 1'b0 || IR2_MUL70 !== 8'h00 || IR2 !== 32'h12340000) begin
            failures++;
            $display("FAIL early_done got busy=%b mul=%h ir2=%h exp 0/00/12340000",
                     MUL_BUSY, IR2_MUL70, IR2);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_bubble();
        test_mul();
        test_flush_mul();
        test_async_reset();
        test_early_term();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
